// File: rtl/hsv_serial_tx.sv
// Serial clock/data driver for the classifier pixel link.
// Shifts 24-bit HSV pixels LSB first and tracks the row-major frame position.
module hsv_serial_tx #(
   parameter int LENGTH      = 40,
   parameter int WIDTH       = 60,
   parameter int HALF_PERIOD = 8000
) (
   input  logic        fpga_clk,
   input  logic        rst,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        ser_clk,
   output logic        ser_data,
   output logic        busy,
   output logic [5:0]  row,
   output logic [5:0]  col,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   localparam logic [15:0] HP_M1    = 16'(HALF_PERIOD - 1);
   localparam logic [5:0]  COL_LAST = 6'(WIDTH - 1);
   localparam logic [5:0]  ROW_LAST = 6'(LENGTH - 1);

   state_t      state, state_nxt;
   logic [15:0] half_cnt;
   logic [4:0]  bit_cnt;
   logic [22:0] shreg;
   logic        half_end, last_bit, accept;

   assign half_end = (half_cnt == HP_M1);
   assign last_bit = (bit_cnt == 5'd23);
   assign accept   = pix_valid && pix_ready;

   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = LOW;
         LOW:     if (half_end) state_nxt = HIGH;
         HIGH:    if (half_end) state_nxt = last_bit ? IDLE : LOW;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pix_ready = (state == IDLE) && !rst;
   end

   // bit 0 goes straight to ser_data on load; shreg holds the remaining 23 bits
   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) begin
         half_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         ser_clk    <= 1'b0;
         ser_data   <= 1'b0;
         busy       <= 1'b0;
         row        <= '0;
         col        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         busy       <= (state_nxt != IDLE);
         case (state)
            IDLE: begin
               ser_clk <= 1'b0;
               if (accept) begin
                  shreg    <= pix_data[23:1];
                  ser_data <= pix_data[0];
                  bit_cnt  <= '0;
                  half_cnt <= '0;
               end else begin
                  ser_data <= 1'b0;
               end
            end
            LOW: begin
               if (half_end) begin
                  half_cnt <= '0;
                  ser_clk  <= 1'b1;
               end else begin
                  half_cnt <= half_cnt + 16'd1;
               end
            end
            HIGH: begin
               if (half_end) begin
                  half_cnt <= '0;
                  ser_clk  <= 1'b0;
                  if (!last_bit) begin
                     bit_cnt  <= bit_cnt + 5'd1;
                     ser_data <= shreg[0];
                     shreg    <= {1'b0, shreg[22:1]};
                  end else begin
                     ser_data <= 1'b0;
                     if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                           row        <= '0;
                           frame_done <= 1'b1;
                        end else begin
                           row <= row + 6'd1;
                        end
                     end else begin
                        col <= col + 6'd1;
                     end
                  end
               end else begin
                  half_cnt <= half_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hsv_serial_tx.sv
// Directed bench for hsv_serial_tx with a short half period and a 2x3 frame.
module tb_hsv_serial_tx;

   localparam int HP = 4;

   logic        fpga_clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready, ser_clk, ser_data, busy, frame_done;
   logic [5:0]  row, col;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fd_cnt = 0;
   int fd_cyc = -1;
   logic prev_clk = 1'b0;
   int   rise_cyc[$];
   logic rise_bit[$];

   hsv_serial_tx #(.LENGTH(2), .WIDTH(3), .HALF_PERIOD(HP)) dut (
      .fpga_clk(fpga_clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .ser_clk(ser_clk), .ser_data(ser_data), .busy(busy),
      .row(row), .col(col), .frame_done(frame_done)
   );

   always #5 fpga_clk = ~fpga_clk;

   // record every serial rising edge with the bit the receiver would sample
   always @(posedge fpga_clk) begin
      #1;
      cyc = cyc + 1;
      if (ser_clk && !prev_clk) begin
         rise_cyc.push_back(cyc);
         rise_bit.push_back(ser_data);
      end
      prev_clk = ser_clk;
      if (frame_done) begin
         fd_cnt = fd_cnt + 1;
         fd_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge fpga_clk);
      #2;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 500; i++) begin
         if (pix_ready) return;
         tick();
      end
      checks++; errors++;
      $display("FAIL wait_ready: pix_ready=%b after 500 cycles, required 1", pix_ready);
   endtask

   task automatic send_pixel(input logic [23:0] d, output int e);
      pix_data  = d;
      pix_valid = 1'b1;
      tick();
      e = cyc;
      pix_valid = 1'b0;
      tick();
      wait_ready();
   endtask

   function automatic logic [23:0] word_at(input int base);
      logic [23:0] w;
      w = '0;
      for (int i = 0; i < 24; i++)
         if (base + i < rise_bit.size()) w[i] = rise_bit[base + i];
      return w;
   endfunction

   task automatic test_reset();
      #1;
      checks++;
      if ({pix_ready, ser_clk, ser_data, busy, frame_done} !== 5'b0 || row !== 6'd0 || col !== 6'd0) begin
         errors++;
         $display("FAIL reset_vals: rdy/clk/dat/busy/fd=%b row=%0d col=%0d, required all 0",
                  {pix_ready, ser_clk, ser_data, busy, frame_done}, row, col);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if (pix_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: pix_ready=%b busy=%b, required 1 0", pix_ready, busy);
      end
   endtask

   task automatic test_single();
      int e, bad;
      rise_cyc.delete(); rise_bit.delete();
      pix_data  = 24'h32503C;
      pix_valid = 1'b1;
      tick();
      e = cyc;
      pix_valid = 1'b0;
      checks++;
      if (pix_ready !== 1'b0 || busy !== 1'b1 || ser_clk !== 1'b0 || ser_data !== 1'b0) begin
         errors++;
         $display("FAIL accept: rdy=%b busy=%b clk=%b dat=%b, required 0 1 0 0",
                  pix_ready, busy, ser_clk, ser_data);
      end
      tick();
      wait_ready();
      checks++;
      if (cyc !== e + 48 * HP) begin
         errors++;
         $display("FAIL ready_time: got E+%0d, required E+%0d", cyc - e, 48 * HP);
      end
      checks++;
      if (rise_cyc.size() !== 24) begin
         errors++;
         $display("FAIL rise_count: got %0d, required 24", rise_cyc.size());
      end else begin
         checks++;
         if (rise_cyc[0] !== e + HP || rise_cyc[23] !== e + 47 * HP) begin
            errors++;
            $display("FAIL rise_edges: first E+%0d last E+%0d, required E+%0d E+%0d",
                     rise_cyc[0] - e, rise_cyc[23] - e, HP, 47 * HP);
         end
         bad = 0;
         for (int i = 1; i < 24; i++) if (rise_cyc[i] - rise_cyc[i-1] != 2 * HP) bad++;
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL rise_spacing: %0d bad gaps, required 0", bad);
         end
      end
      checks++;
      if (word_at(0) !== 24'h32503C) begin
         errors++;
         $display("FAIL single_word: got %h, required 32503c", word_at(0));
      end
      checks++;
      if (row !== 6'd0 || col !== 6'd1 || fd_cnt !== 0) begin
         errors++;
         $display("FAIL single_pos: row=%0d col=%0d fd=%0d, required 0 1 0", row, col, fd_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int ea;
      rise_cyc.delete(); rise_bit.delete();
      pix_data  = 24'hA1B2C3;
      pix_valid = 1'b1;
      tick();
      ea = cyc;
      pix_data = 24'h5E6F70;
      tick();
      wait_ready();
      checks++;
      if (ser_clk !== 1'b0 || ser_data !== 1'b0) begin
         errors++;
         $display("FAIL gap_idle: clk=%b dat=%b, required 0 0", ser_clk, ser_data);
      end
      tick();
      checks++;
      if (cyc !== ea + 48 * HP + 1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got E+%0d busy=%b, required E+%0d busy=1",
                  cyc - ea, busy, 48 * HP + 1);
      end
      pix_valid = 1'b0;
      tick();
      wait_ready();
      checks++;
      if (rise_cyc.size() !== 48) begin
         errors++;
         $display("FAIL b2b_rises: got %0d, required 48", rise_cyc.size());
      end else begin
         checks++;
         if (rise_cyc[24] - rise_cyc[23] !== 2 * HP + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles, required %0d", rise_cyc[24] - rise_cyc[23], 2 * HP + 1);
         end
      end
      checks++;
      if (word_at(0) !== 24'hA1B2C3 || word_at(24) !== 24'h5E6F70) begin
         errors++;
         $display("FAIL b2b_words: got %h %h, required a1b2c3 5e6f70", word_at(0), word_at(24));
      end
      checks++;
      if (row !== 6'd1 || col !== 6'd0) begin
         errors++;
         $display("FAIL b2b_pos: row=%0d col=%0d, required 1 0", row, col);
      end
   endtask

   task automatic test_mid_reset();
      int e;
      pix_data  = 24'h000400;
      pix_valid = 1'b1;
      tick();
      e = cyc;
      pix_valid = 1'b0;
      for (int i = 0; i < 85; i++) tick();
      checks++;
      if (ser_clk !== 1'b1 || ser_data !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bit10_state: clk=%b dat=%b busy=%b at E+%0d, required 1 1 1", ser_clk, ser_data, busy, cyc - e);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ser_clk !== 1'b0 || ser_data !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: clk=%b dat=%b busy=%b rdy=%b, required 0 0 0 0",
                  ser_clk, ser_data, busy, pix_ready);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if (pix_ready !== 1'b1 || row !== 6'd0 || col !== 6'd0) begin
         errors++;
         $display("FAIL post_reset: rdy=%b row=%0d col=%0d, required 1 0 0", pix_ready, row, col);
      end
      rise_cyc.delete(); rise_bit.delete();
      send_pixel(24'hFFFFFF, e);
      checks++;
      if (rise_cyc.size() !== 24 || word_at(0) !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL ones_word: rises=%0d word=%h, required 24 ffffff", rise_cyc.size(), word_at(0));
      end
   endtask

   task automatic test_frame();
      int e;
      logic [5:0] er, ec;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      fd_cnt = 0;
      fd_cyc = -1;
      e = 0;
      for (int i = 0; i < 6; i++) begin
         er = 6'(i / 3);
         ec = 6'(i % 3);
         checks++;
         if (row !== er || col !== ec) begin
            errors++;
            $display("FAIL frame_pos%0d: row=%0d col=%0d, required %0d %0d", i, row, col, er, ec);
         end
         if (i < 5) begin
            checks++;
            if (fd_cnt !== 0) begin
               errors++;
               $display("FAIL early_fd%0d: frame_done count %0d, required 0", i, fd_cnt);
            end
         end
         send_pixel(24'h010203 + 24'(i), e);
      end
      checks++;
      if (fd_cnt !== 1 || fd_cyc !== e + 48 * HP) begin
         errors++;
         $display("FAIL frame_done: count=%0d at E+%0d, required 1 at E+%0d", fd_cnt, fd_cyc - e, 48 * HP);
      end
      checks++;
      if (row !== 6'd0 || col !== 6'd0) begin
         errors++;
         $display("FAIL frame_wrap: row=%0d col=%0d, required 0 0", row, col);
      end
      send_pixel(24'h777777, e);
      checks++;
      if (fd_cnt !== 1 || col !== 6'd1) begin
         errors++;
         $display("FAIL seventh: fd count=%0d col=%0d, required 1 1", fd_cnt, col);
      end
   endtask

   task automatic test_data_hold();
      int e;
      rise_cyc.delete(); rise_bit.delete();
      pix_data  = 24'hA5C33C;
      pix_valid = 1'b1;
      tick();
      e = cyc;
      for (int i = 0; i < 500 && !pix_ready; i++) begin
         pix_data = ~pix_data;
         tick();
      end
      pix_valid = 1'b0;
      checks++;
      if (cyc !== e + 48 * HP || rise_cyc.size() !== 24) begin
         errors++;
         $display("FAIL hold_reload: ready at E+%0d rises=%0d, required E+%0d 24",
                  cyc - e, rise_cyc.size(), 48 * HP);
      end
      checks++;
      if (word_at(0) !== 24'hA5C33C) begin
         errors++;
         $display("FAIL hold_word: got %h, required a5c33c", word_at(0));
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_mid_reset();
      test_frame();
      test_data_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
